// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
//
// Dispatch controller between rename and the three reservation stations
// (ALU, branch, memory). Renamed instructions are buffered in a 2-entry
// in-order FIFO. The head entry is offered to exactly one reservation
// station, chosen from its functional-unit bits. A ROB credit counter
// limits the number of instructions in flight to ROB_DEPTH. A mispredict
// flushes the FIFO and reloads the credits.
//
// rename_data layout (DATA_W bits, flat vector):
//   [0]          fu_alu
//   [1]          fu_br
//   [2]          fu_mem
//   [6:3]        rob_tag
//   [DATA_W-1:7] operands / payload
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   reset                asynchronous active-high reset
//   valid_in             rename output valid
//   data_in              renamed instruction (rename_data)
//   ready_in             dispatch can accept data_in this cycle
//   rs_data              FIFO head, shared by all three RS (0 when empty)
//   alu_valid/br_valid/mem_valid   head targets that RS
//   alu_ready/br_ready/mem_ready   RS has a free slot
//   rob_alloc            pulse: ROB entry allocated this cycle
//   rob_alloc_tag        rob_tag of the allocated entry
//   commit_en            ROB retired one instruction this cycle
//   mispredict           flush request from the ROB
//   mispredict_inflight  ROB entries surviving the flush (0..16)
//   credits              current free ROB slots
module dispatch_ctrl #(
    parameter int ROB_DEPTH  = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] rs_data,
    output logic              alu_valid,
    output logic              br_valid,
    output logic              mem_valid,
    input  logic              alu_ready,
    input  logic              br_ready,
    input  logic              mem_ready,
    output logic              rob_alloc,
    output logic [3:0]        rob_alloc_tag,
    input  logic              commit_en,
    input  logic              mispredict,
    input  logic [4:0]        mispredict_inflight,
    output logic [4:0]        credits
);

    localparam logic [4:0] ROB_FULL   = 5'(ROB_DEPTH);
    localparam logic [1:0] FIFO_FULL  = 2'(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [4:0]        credits_q;

    logic [DATA_W-1:0] head;
    logic              nonempty;
    logic              sel_br;
    logic              sel_mem;
    logic              sel_alu;
    logic              acc;
    logic              issue;

    // Credits after a flush; out-of-range survivor counts clamp to zero credits.
    function automatic logic [4:0] flush_credits(input logic [4:0] inflight);
        if (inflight >= ROB_FULL)
            return 5'd0;
        else
            return ROB_FULL - inflight;
    endfunction

    // A commit with no allocation never pushes the counter past ROB_DEPTH,
    // so a spurious commit when the ROB is already empty is absorbed.
    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        if (c >= ROB_FULL)
            return ROB_FULL;
        else
            return c + 5'd1;
    endfunction

    always_comb begin
        head     = fifo_mem[rd_ptr];
        nonempty = (count != 2'd0);

        // Branch wins over memory, memory over ALU; no FU bit means ALU
        // (LUI/AUIPC/JAL).
        sel_br   = nonempty && head[1];
        sel_mem  = nonempty && !head[1] && head[2];
        sel_alu  = nonempty && !head[1] && !head[2];

        // Depends only on registered state and mispredict, never on RS
        // readies, so rename sees no combinational path from the RS.
        ready_in = (count != FIFO_FULL) && (credits_q != 5'd0) && !mispredict;
        acc      = valid_in && ready_in;
        issue    = (sel_br && br_ready) || (sel_mem && mem_ready) ||
                   (sel_alu && alu_ready);

        rs_data       = nonempty ? head : '0;
        alu_valid     = sel_alu;
        br_valid      = sel_br;
        mem_valid     = sel_mem;
        rob_alloc     = acc;
        rob_alloc_tag = acc ? data_in[6:3] : 4'd0;
        credits       = credits_q;
    end

    // FIFO storage carries data only; an empty FIFO masks it at rs_data.
    always_ff @(posedge clk) begin
        if (acc)
            fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            credits_q <= ROB_FULL;
        end else if (mispredict) begin
            // commit_en is already folded into mispredict_inflight by the ROB.
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            credits_q <= flush_credits(mispredict_inflight);
        end else begin
            if (acc)
                wr_ptr <= ~wr_ptr;
            if (issue)
                rd_ptr <= ~rd_ptr;

            case ({acc, issue})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            case ({acc, commit_en})
                2'b10:   credits_q <= credits_q - 5'd1;
                2'b01:   credits_q <= sat_inc(credits_q);
                default: credits_q <= credits_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Testbench for dispatch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared against a queue-based model.
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] data_in;
    logic        ready_in;
    logic [31:0] rs_data;
    logic        alu_valid, br_valid, mem_valid;
    logic        alu_ready, br_ready, mem_ready;
    logic        rob_alloc;
    logic [3:0]  rob_alloc_tag;
    logic        commit_en;
    logic        mispredict;
    logic [4:0]  mispredict_inflight;
    logic [4:0]  credits;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dispatch_ctrl #(.ROB_DEPTH(16), .FIFO_DEPTH(2), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .rs_data(rs_data),
        .alu_valid(alu_valid), .br_valid(br_valid), .mem_valid(mem_valid),
        .alu_ready(alu_ready), .br_ready(br_ready), .mem_ready(mem_ready),
        .rob_alloc(rob_alloc), .rob_alloc_tag(rob_alloc_tag),
        .commit_en(commit_en), .mispredict(mispredict),
        .mispredict_inflight(mispredict_inflight), .credits(credits)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // fu = {fu_mem, fu_br, fu_alu}
    function automatic logic [31:0] mk(input logic [2:0] fu, input logic [3:0] tag);
        logic [31:0] r;
        r = $urandom();
        return {r[24:0], tag, fu};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int          mcred = 16;

    always @(negedge clk) begin
        logic [31:0] d;
        bit eb, em, ea, eready, eacc, eissue;
        int infl;
        if (reset) begin
            mq.delete();
            mcred = 16;
            check("rst_credits", 32'(credits), 32'd16);
            check("rst_valids", {29'd0, alu_valid, br_valid, mem_valid}, 32'd0);
            check("rst_rs_data", rs_data, 32'd0);
            check("rst_ready_in", 32'(ready_in), 32'(!mispredict));
        end else begin
            d  = (mq.size() > 0) ? mq[0] : 32'd0;
            eb = (mq.size() > 0) && d[1];
            em = (mq.size() > 0) && !d[1] && d[2];
            ea = (mq.size() > 0) && !d[1] && !d[2];
            eready = (mq.size() < 2) && (mcred > 0) && !mispredict;
            eacc   = valid_in && eready;
            eissue = (eb && br_ready) || (em && mem_ready) || (ea && alu_ready);

            check("ready_in", 32'(ready_in), 32'(eready));
            check("valids", {29'd0, alu_valid, br_valid, mem_valid}, {29'd0, ea, eb, em});
            check("rs_data", rs_data, d);
            check("rob_alloc", 32'(rob_alloc), 32'(eacc));
            if (eacc)
                check("rob_alloc_tag", 32'(rob_alloc_tag), 32'(data_in[6:3]));
            check("credits", 32'(credits), 32'(mcred));

            if (mispredict) begin
                mq.delete();
                infl  = int'(mispredict_inflight);
                mcred = 16 - ((infl > 16) ? 16 : infl);
            end else begin
                if (eissue) void'(mq.pop_front());
                if (eacc) mq.push_back(data_in);
                if (eacc && !commit_en) mcred--;
                else if (commit_en && !eacc) mcred = (mcred >= 16) ? 16 : mcred + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 0; commit_en = 0; mispredict = 0; mispredict_inflight = 0;
    endtask

    initial begin
        reset = 1; idle(); data_in = 0;
        alu_ready = 1; br_ready = 1; mem_ready = 1;
        tick(); tick();
        reset = 0;
        tick();
        check("lit_reset_credits", 32'(credits), 32'd16);
        check("lit_reset_ready", 32'(ready_in), 32'd1);
        check("lit_reset_rs_data", rs_data, 32'd0);

        // Three back-to-back accepts: ALU, BR, MEM
        valid_in = 1; data_in = mk(3'b001, 4'd0);
        #1 check("lit_tag0", 32'(rob_alloc_tag), 32'd0);
        tick();
        check("lit_c1_alu", {29'd0, alu_valid, br_valid, mem_valid}, 32'b100);
        data_in = mk(3'b010, 4'd1);
        #1 check("lit_tag1", 32'(rob_alloc_tag), 32'd1);
        tick();
        check("lit_c2_br", {29'd0, alu_valid, br_valid, mem_valid}, 32'b010);
        data_in = mk(3'b100, 4'd2);
        #1 check("lit_tag2", 32'(rob_alloc_tag), 32'd2);
        tick();
        check("lit_c3_mem", {29'd0, alu_valid, br_valid, mem_valid}, 32'b001);
        valid_in = 0;
        tick();
        check("lit_credits_13", 32'(credits), 32'd13);

        // ALU stalled: two accepted, third held off
        alu_ready = 0;
        valid_in = 1; data_in = mk(3'b001, 4'd3); tick();
        data_in = mk(3'b001, 4'd4); tick();
        check("lit_full_ready", 32'(ready_in), 32'd0);
        check("lit_hold_tag3", 32'(rs_data[6:3]), 32'd3);
        data_in = mk(3'b001, 4'd5);
        alu_ready = 1;
        tick();
        check("lit_drain_tag4", 32'(rs_data[6:3]), 32'd4);
        check("lit_ready_back", 32'(ready_in), 32'd1);
        tick();
        valid_in = 0;
        tick(); tick();

        // Commits refill to 16 and saturate
        commit_en = 1;
        repeat (8) tick();
        commit_en = 0;
        check("lit_credits_sat16", 32'(credits), 32'd16);

        // 16 accepts without commits
        valid_in = 1;
        for (int i = 0; i < 16; i++) begin
            data_in = mk(3'b001, 4'(i));
            tick();
        end
        check("lit_credits_0", 32'(credits), 32'd0);
        check("lit_ready_0", 32'(ready_in), 32'd0);
        data_in = mk(3'b001, 4'd0);
        tick();
        check("lit_17th_blocked", 32'(credits), 32'd0);
        commit_en = 1; tick(); commit_en = 0;
        check("lit_credits_1", 32'(credits), 32'd1);
        check("lit_ready_1", 32'(ready_in), 32'd1);
        tick();
        check("lit_17th_taken", 32'(credits), 32'd0);
        valid_in = 0;

        // Accept and commit together at credits 5
        commit_en = 1;
        repeat (5) tick();
        check("lit_credits_5", 32'(credits), 32'd5);
        valid_in = 1; data_in = mk(3'b100, 4'd7);
        tick();
        check("lit_acc_commit_5", 32'(credits), 32'd5);
        idle(); tick();

        // Routing priority with readies low
        alu_ready = 0; br_ready = 0; mem_ready = 0;
        valid_in = 1; data_in = mk(3'b110, 4'd8); tick(); valid_in = 0;
        check("lit_br_mem_to_br", {29'd0, alu_valid, br_valid, mem_valid}, 32'b010);
        br_ready = 1; tick(); br_ready = 0;
        valid_in = 1; data_in = mk(3'b000, 4'd9); tick(); valid_in = 0;
        check("lit_nofu_to_alu", {29'd0, alu_valid, br_valid, mem_valid}, 32'b100);
        tick();

        // Mispredict with two entries buffered plus the stalled one
        valid_in = 1; data_in = mk(3'b001, 4'd10); tick();
        mispredict = 1; mispredict_inflight = 5'd4; commit_en = 1;
        data_in = mk(3'b001, 4'd11);
        #1;
        check("lit_flush_no_alloc", 32'(rob_alloc), 32'd0);
        check("lit_flush_alu_head", 32'(alu_valid), 32'd1);
        tick();
        idle();
        #1;
        check("lit_flush_credits_12", 32'(credits), 32'd12);
        check("lit_flush_empty", {29'd0, alu_valid, br_valid, mem_valid}, 32'd0);

        // Clamp of out-of-range survivor count
        mispredict = 1; mispredict_inflight = 5'd20; tick();
        mispredict = 0;
        check("lit_clamp_credits_0", 32'(credits), 32'd0);
        alu_ready = 1; br_ready = 1; mem_ready = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            mispredict = ($urandom_range(0, 29) == 0);
            mispredict_inflight = 5'($urandom_range(0, 20));
            commit_en  = ($urandom_range(0, 2) == 0);
            valid_in   = !reset && ($urandom_range(0, 2) != 0);
            data_in    = mk(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            alu_ready  = ($urandom_range(0, 3) != 0);
            br_ready   = ($urandom_range(0, 3) != 0);
            mem_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 0; idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
